// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared definitions for the data-cache miss sequencer and the decoder's
// cache controller: FSM states and the mux-select encodings.
package dcache_miss_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } miss_state_t;

  localparam logic CACHE_IN_CPU    = 1'b0;
  localparam logic CACHE_IN_MEM    = 1'b1;
  localparam logic MEM_ADDR_REQ    = 1'b0;
  localparam logic MEM_ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/dcache_miss_ctrl_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count one event per cycle, holding once all ones is reached
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: stalls the pipeline on a miss, writes back a
// dirty victim if needed, refills the line, and then lets the access replay
// as a hit. Also keeps hit, miss and writeback counters.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              we_cache,
  output logic              cache_input_type,
  output logic              memory_address_type,
  output logic              set_dirty,
  output logic              set_valid,
  output logic              pc_enable,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  miss_state_t       state, next_state;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] victim_addr_q;
  logic              latch_addr;
  logic              hit_inc, miss_inc, wb_inc;

  // State register plus the line addresses captured when the miss is seen
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      req_addr_q    <= '0;
      victim_addr_q <= '0;
    end else begin
      state <= next_state;
      if (latch_addr) begin
        req_addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
        victim_addr_q <= victim_addr;
      end
    end
  end

  // Next state, cache/memory controls and counter events; everything is
  // held quiet while reset is asserted so an aborted transfer commits nothing
  always_comb begin
    next_state          = state;
    mem_req             = 1'b0;
    mem_write_en        = 1'b0;
    mem_addr            = '0;
    we_cache            = 1'b0;
    cache_input_type    = CACHE_IN_CPU;
    memory_address_type = MEM_ADDR_REQ;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    pc_enable           = 1'b1;
    latch_addr          = 1'b0;
    hit_inc             = 1'b0;
    miss_inc            = 1'b0;
    wb_inc              = 1'b0;
    if (rst_b) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (cache_hit) begin
              hit_inc = 1'b1;
              if (req_write) begin
                we_cache         = 1'b1;
                cache_input_type = CACHE_IN_CPU;
                set_dirty        = 1'b1;
                set_valid        = 1'b1;
              end
            end else begin
              pc_enable  = 1'b0;
              latch_addr = 1'b1;
              miss_inc   = 1'b1;
              if (cache_dirty) begin
                next_state = WRITEBACK;
                wb_inc     = 1'b1;
              end else begin
                next_state = REFILL;
              end
            end
          end
        end
        WRITEBACK: begin
          mem_req             = 1'b1;
          mem_write_en        = 1'b1;
          memory_address_type = MEM_ADDR_VICTIM;
          mem_addr            = victim_addr_q;
          pc_enable           = 1'b0;
          if (mem_ready) begin
            next_state = REFILL;
          end
        end
        REFILL: begin
          mem_req             = 1'b1;
          memory_address_type = MEM_ADDR_REQ;
          mem_addr            = req_addr_q;
          pc_enable           = 1'b0;
          if (mem_ready) begin
            we_cache         = 1'b1;
            cache_input_type = CACHE_IN_MEM;
            set_valid        = 1'b1;
            set_dirty        = 1'b0;
            next_state       = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (hit_inc),
    .value (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (miss_inc),
    .value (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (wb_inc),
    .value (wb_count)
  );

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: each step drives one cycle of inputs,
// queues the outputs expected for that cycle and compares them mid-cycle.
module tb_dcache_miss_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic        we_cache;
    logic        cache_input_type;
    logic        memory_address_type;
    logic        set_dirty;
    logic        set_valid;
    logic        pc_enable;
  } outv_t;

  typedef struct {
    string tag;
    outv_t exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_write, cache_hit, cache_dirty, mem_ready;
  logic [31:0] req_addr, victim_addr;
  logic        mem_req, mem_write_en, we_cache, cache_input_type;
  logic        memory_address_type, set_dirty, set_valid, pc_enable;
  logic [31:0] mem_addr, hit_count, miss_count, wb_count;

  sb_t scoreboard[$];
  int  vectors     = 0;
  int  miscompares = 0;

  dcache_miss_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk                 (clk),
    .rst_b               (rst_b),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .victim_addr         (victim_addr),
    .cache_hit           (cache_hit),
    .cache_dirty         (cache_dirty),
    .mem_ready           (mem_ready),
    .mem_req             (mem_req),
    .mem_write_en        (mem_write_en),
    .mem_addr            (mem_addr),
    .we_cache            (we_cache),
    .cache_input_type    (cache_input_type),
    .memory_address_type (memory_address_type),
    .set_dirty           (set_dirty),
    .set_valid           (set_valid),
    .pc_enable           (pc_enable),
    .hit_count           (hit_count),
    .miss_count          (miss_count),
    .wb_count            (wb_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic outv_t mk(input logic req, input logic wen, input logic [31:0] addr,
                               input logic we, input logic cit, input logic mat,
                               input logic sd, input logic sv, input logic pc);
    outv_t o;
    o.mem_req             = req;
    o.mem_write_en        = wen;
    o.mem_addr            = addr;
    o.we_cache            = we;
    o.cache_input_type    = cit;
    o.memory_address_type = mat;
    o.set_dirty           = sd;
    o.set_valid           = sv;
    o.pc_enable           = pc;
    return o;
  endfunction

  function automatic outv_t e_idle();
    return mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic outv_t e_store_hit();
    return mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endfunction

  function automatic outv_t e_detect();
    return mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic outv_t e_wb(input logic [31:0] addr);
    return mk(1'b1, 1'b1, addr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic outv_t e_refill(input logic [31:0] addr, input logic done);
    return mk(1'b1, 1'b0, addr, done, done, 1'b0, 1'b0, done, 1'b0);
  endfunction

  // Pop the oldest expectation and compare it with what the DUT drives now
  task automatic checkOutput();
    sb_t   item;
    outv_t obs;
    item = scoreboard.pop_front();
    obs  = mk(mem_req, mem_write_en, mem_addr, we_cache, cache_input_type,
              memory_address_type, set_dirty, set_valid, pc_enable);
    vectors++;
    assert (obs === item.exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge and check mid-cycle
  task automatic applyStimulus(input string tag, input logic v, input logic w,
                               input logic [31:0] a, input logic [31:0] va,
                               input logic hit, input logic dirty, input logic ready,
                               input outv_t e);
    sb_t item;
    @(negedge clk);
    req_valid   = v;
    req_write   = w;
    req_addr    = a;
    victim_addr = va;
    cache_hit   = hit;
    cache_dirty = dirty;
    mem_ready   = ready;
    item.tag = tag;
    item.exp = e;
    scoreboard.push_back(item);
    #2;
    checkOutput();
  endtask

  // Counters are read with the request dropped so nothing moves meanwhile
  task automatic checkCounters(input string tag, input bit wait_cycle,
                               input logic [31:0] h, input logic [31:0] m,
                               input logic [31:0] w);
    if (wait_cycle) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b0;
      #2;
    end
    vectors++;
    assert (hit_count === h) else begin
      miscompares++;
      $error("[TB] FAIL %s_hit observed=%h expected=%h", tag, hit_count, h);
    end
    vectors++;
    assert (miss_count === m) else begin
      miscompares++;
      $error("[TB] FAIL %s_miss observed=%h expected=%h", tag, miss_count, m);
    end
    vectors++;
    assert (wb_count === w) else begin
      miscompares++;
      $error("[TB] FAIL %s_wb observed=%h expected=%h", tag, wb_count, w);
    end
  endtask

  initial begin
    sb_t item;
    rst_b       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 32'h0;
    victim_addr = 32'h0;
    cache_hit   = 1'b0;
    cache_dirty = 1'b0;
    mem_ready   = 1'b0;

    // Reset state
    #2;
    item.tag = "reset_outputs";
    item.exp = e_idle();
    scoreboard.push_back(item);
    checkOutput();
    checkCounters("reset_cnt", 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Load hits, with mem_ready toggled in IDLE where it must be ignored
    for (int i = 0; i < 3; i++)
      applyStimulus("load_hit", 1, 0, 32'h100, 32'h0, 1, 0, 1, e_idle());
    checkCounters("after_load_hits", 1'b1, 32'd3, 32'd0, 32'd0);
    applyStimulus("no_req", 0, 0, 32'h100, 32'h0, 0, 1, 1, e_idle());

    // Store hit merges CPU data and marks the line dirty without stalling
    applyStimulus("store_hit", 1, 1, 32'h40, 32'h0, 1, 0, 0, e_store_hit());
    checkCounters("after_store_hit", 1'b1, 32'd4, 32'd0, 32'd0);

    // Clean load miss; request lines change mid-refill and must be ignored
    applyStimulus("clean_detect", 1, 0, 32'h1004, 32'h5000, 0, 0, 0, e_detect());
    applyStimulus("clean_refill1", 1, 0, 32'h1004, 32'h5000, 0, 0, 0, e_refill(32'h1004, 0));
    applyStimulus("clean_refill2", 0, 0, 32'hDEADBEEF, 32'h5000, 0, 0, 0, e_refill(32'h1004, 0));
    applyStimulus("clean_refill3", 1, 0, 32'h1004, 32'h5000, 0, 0, 0, e_refill(32'h1004, 0));
    applyStimulus("clean_refill_done", 1, 0, 32'h1004, 32'h5000, 0, 0, 1, e_refill(32'h1004, 1));
    applyStimulus("clean_replay", 1, 0, 32'h1004, 32'h5000, 1, 0, 0, e_idle());
    checkCounters("after_clean_miss", 1'b1, 32'd5, 32'd1, 32'd0);

    // Dirty store miss with single-cycle memory transfers
    applyStimulus("dirty_detect", 1, 1, 32'h2000, 32'h0800, 0, 1, 1, e_detect());
    applyStimulus("dirty_wb", 1, 1, 32'h2000, 32'h0800, 0, 1, 1, e_wb(32'h0800));
    applyStimulus("dirty_refill", 1, 1, 32'h2000, 32'h0800, 0, 1, 1, e_refill(32'h2000, 1));
    applyStimulus("dirty_replay", 1, 1, 32'h2000, 32'h0800, 1, 0, 0, e_store_hit());
    checkCounters("after_dirty_miss", 1'b1, 32'd6, 32'd2, 32'd1);

    // Asynchronous reset in the middle of a refill
    applyStimulus("rst_detect", 1, 0, 32'h3000, 32'h0, 0, 0, 0, e_detect());
    applyStimulus("rst_refill", 1, 0, 32'h3000, 32'h0, 0, 0, 0, e_refill(32'h3000, 0));
    #1;
    rst_b     = 1'b0;
    mem_ready = 1'b1;
    #1;
    item.tag = "reset_mid_refill";
    item.exp = e_idle();
    scoreboard.push_back(item);
    checkOutput();
    checkCounters("reset_mid_cnt", 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    rst_b     = 1'b1;
    applyStimulus("rerun_detect", 1, 0, 32'h3000, 32'h0, 0, 0, 0, e_detect());
    applyStimulus("rerun_refill", 1, 0, 32'h3000, 32'h0, 0, 0, 1, e_refill(32'h3000, 1));
    applyStimulus("rerun_replay", 1, 0, 32'h3000, 32'h0, 1, 0, 0, e_idle());
    checkCounters("after_rerun", 1'b1, 32'd1, 32'd1, 32'd0);

    // Miss counter saturation; unaligned request address gets word-aligned
    @(negedge clk);
    force dut.u_miss_cnt.value = 32'hFFFF_FFFE;
    #1;
    release dut.u_miss_cnt.value;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sat_detect", 1, 0, 32'h3007, 32'h0, 0, 0, 0, e_detect());
      applyStimulus("sat_refill", 1, 0, 32'h3007, 32'h0, 0, 0, 1, e_refill(32'h3004, 1));
      applyStimulus("sat_replay", 1, 0, 32'h3007, 32'h0, 1, 0, 0, e_idle());
      if (i == 0)
        checkCounters("sat_first", 1'b1, 32'd2, 32'hFFFF_FFFF, 32'd0);
    end
    checkCounters("sat_final", 1'b1, 32'd4, 32'hFFFF_FFFF, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
